instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- Initiator side of the instruction memory read interface: owns the PC, drives the word-aligned fetch address, and captures the returned instruction word in the same cycle.
- Buffers fetched words in a small prefetch FIFO and hands them to decode over a valid/ready handshake.
- Sits between the instruction memory and the decode stage; branch/jump redirects from execute flush the buffer and reload the PC.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- FIFO_DEPTH, 2, prefetch entries; legal values 2..8.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst  in  1  asynchronous, active-low reset.
- Address  out  32  fetch address to instruction memory; always equals PC, bits [1:0] = 0.
- Instruction  in  32  combinational read data for Address, valid in the same cycle.
- InstrOut  out  32  instruction word at the FIFO head.
- PCPlus4Out  out  32  fetch address of the head entry + 4.
- InstrValid  out  1  head entry valid.
- InstrReady  in  1  decode accepts the head entry this cycle.
- Redirect  in  1  flush and reload PC (taken branch or jump).
- RedirectTarget  in  32  new PC; bits [1:0] are forced to 0.
- Halt  in  1  stop issuing new fetches.

Behaviour:
- Reset (Rst=0, async):
  - PC = RESET_PC; FIFO count = 0; state = RUN.
  - InstrValid = 0; InstrOut = 0; PCPlus4Out = 0.
- FSM states:
  - RUN: fetch every cycle unless the FIFO is full.
  - HALTED: no fetches; FIFO continues draining to decode.
- FSM transitions:
  - RUN -> HALTED when Halt = 1.
  - HALTED -> RUN when Halt = 0.
  - Redirect in either state leaves the state unchanged but still flushes and reloads PC.
- Push rule:
  - A push occurs when state = RUN, Redirect = 0, and (count < FIFO_DEPTH or the head is popped this cycle).
  - The entry written is {Instruction, PC+4}, and PC <= PC+4 on the same edge.
- Pop rule: pop when InstrValid & InstrReady. Push and pop in the same cycle leave the count unchanged.
- Full FIFO without a pop: no push, PC holds, Address holds.
- Redirect has the highest priority:
  - On the edge: count <= 0, PC <= {RedirectTarget[31:2], 2'b00}.
  - No push and no pop that cycle; InstrReady is ignored.
- Latency:
  - Redirect asserted in cycle N -> InstrValid = 0 in N+1; target instruction at the head in N+2.
  - Reset release before edge E -> first instruction valid after edge E.
- Outputs InstrOut, PCPlus4Out and InstrValid come straight from FIFO registers; there is no combinational path from Instruction to them.
- InstrOut and PCPlus4Out are don't-care while InstrValid = 0, but are held stable while InstrValid = 1 and InstrReady = 0.
- PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0. Range checking against memory size is not performed here.
- Halt and Redirect in the same cycle: the flush and PC reload happen, and the state goes to HALTED.
- Reset mid-operation clears the FIFO immediately; outputs are forced to their reset values asynchronously.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- With it defined, three 32-bit outputs are added, all reset to 0 and wrapping modulo 2^32:
  - FetchCount: increments per push.
  - StallCount: increments per cycle in RUN with a full FIFO and no pop.
  - FlushCount: increments per Redirect.
- Without it, those ports and their counters do not exist, and the behaviour is otherwise identical.

Decomposition:
- Package fetch_pkg holds:
  - fetch_state_t enum {RUN, HALTED};
  - fetch_entry_t struct {instr[31:0], pc_plus4[31:0]};
  - the WORD_ALIGN_MASK constant 32'hFFFF_FFFC.
- Sub-module fetch_fifo provides a synchronous FIFO of fetch_entry_t with:
  - inputs push, pop, flush;
  - outputs head, count, full, empty;
  - flush taking priority over push and pop.

Test Plan:
- Memory model word[i] = i*4, InstrReady held 1, reset released: InstrOut sequence 0x0, 0x4, 0x8, … one per cycle, with PCPlus4Out = InstrOut + 4.
- InstrReady = 0 for 5 cycles with FIFO_DEPTH = 2: two entries buffered, Address frozen at 0x8. Raising InstrReady then yields 0x0, 0x4, 0x8 with no gap or duplicate.
- Redirect with RedirectTarget = 0x43 while the FIFO is full: InstrValid = 0 in the next cycle, and in the cycle after, InstrOut = 0x40 and PCPlus4Out = 0x44. No stale entry ever appears.
- Halt = 1 with 2 entries buffered: both entries drain, Address stays constant, InstrValid then stays 0. Dropping Halt resumes fetch at the held PC.
- RESET_PC = 32'hFFFF_FFF8 with ready held 1: heads are FFFF_FFF8, FFFF_FFFC, 0000_0000 (PC wraps).
- Rst pulsed low mid-stream for less than a clock period: InstrValid drops immediately, and fetch restarts at RESET_PC. With FETCH_PERF_CNT_EN defined, all counters read 0 after the pulse.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit: FSM state, prefetch entry, alignment helpers.
package fetch_pkg;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
  } fetch_entry_t;

  localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & WORD_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus: instruction memory read port, decode handshake and execute redirect.
// Optional FETCH_PERF_CNT_EN adds the fetch/stall/flush counters to the bundle.
interface instruction_fetch_unit_if;
  logic [31:0] Address;
  logic [31:0] Instruction;
  logic [31:0] InstrOut;
  logic [31:0] PCPlus4Out;
  logic        InstrValid;
  logic        InstrReady;
  logic        Redirect;
  logic [31:0] RedirectTarget;
  logic        Halt;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] FetchCount;
  logic [31:0] StallCount;
  logic [31:0] FlushCount;

  modport master (
    output Address, InstrOut, PCPlus4Out, InstrValid,
    input  Instruction, InstrReady, Redirect, RedirectTarget, Halt,
    output FetchCount, StallCount, FlushCount
  );
  modport slave (
    input  Address, InstrOut, PCPlus4Out, InstrValid,
    output Instruction, InstrReady, Redirect, RedirectTarget, Halt,
    input  FetchCount, StallCount, FlushCount
  );
`else
  modport master (
    output Address, InstrOut, PCPlus4Out, InstrValid,
    input  Instruction, InstrReady, Redirect, RedirectTarget, Halt
  );
  modport slave (
    input  Address, InstrOut, PCPlus4Out, InstrValid,
    output Instruction, InstrReady, Redirect, RedirectTarget, Halt
  );
`endif
endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of fetch entries; flush beats push and pop, DEPTH need not be a power of two.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  fetch_entry_t                 wdata,
  output fetch_entry_t                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Storage is cleared on reset so the head reads zero while the bus is idle.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: owns the PC, fetches one word per cycle into a prefetch FIFO, flushes on redirect.
// Define FETCH_PERF_CNT_EN to add FetchCount/StallCount/FlushCount outputs.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input logic                      Clk,
  input logic                      Rst,
  instruction_fetch_unit_if.master bus
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  fetch_state_t     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic             fetch_en;
  logic             push, pop;
  fetch_entry_t     wr_entry, head;
  logic [CNT_W-1:0] count;
  logic             full, empty;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state_q <= RUN;
    else      state_q <= state_d;
  end

  // Redirect never moves the FSM; only Halt does.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (bus.Halt)  state_d = HALTED;
      HALTED:  if (!bus.Halt) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    fetch_en = (state_q == RUN);
  end

  // Redirect suppresses both sides of the FIFO so no stale word slips through.
  assign pop      = ~empty & bus.InstrReady & ~bus.Redirect;
  assign push     = fetch_en & ~bus.Redirect & ((count < CNT_W'(FIFO_DEPTH)) | pop);
  assign wr_entry = '{instr: bus.Instruction, pc_plus4: pc_q + 32'd4};

  always_comb begin
    pc_d = pc_q;
    if (bus.Redirect) pc_d = word_align(bus.RedirectTarget);
    else if (push)    pc_d = pc_q + 32'd4;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) pc_q <= RESET_PC;
    else      pc_q <= pc_d;
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .Clk   (Clk),
    .Rst   (Rst),
    .push  (push),
    .pop   (pop),
    .flush (bus.Redirect),
    .wdata (wr_entry),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign bus.Address    = pc_q;
  assign bus.InstrOut   = head.instr;
  assign bus.PCPlus4Out = head.pc_plus4;
  assign bus.InstrValid = ~empty;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q + {31'd0, push};
    stall_cnt_d = stall_cnt_q + {31'd0, fetch_en & full & ~pop};
    flush_cnt_d = flush_cnt_q + {31'd0, bus.Redirect};
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.FetchCount = fetch_cnt_q;
  assign bus.StallCount = stall_cnt_q;
  assign bus.FlushCount = flush_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: queue-based reference model checked every cycle plus directed literals.
module tb_instruction_fetch_unit;
  localparam int DEPTH = 2;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  always #5 Clk = ~Clk;

  instruction_fetch_unit_if ifc ();
  instruction_fetch_unit_if ifc2 ();

  // Memory model: word at address A holds A.
  assign ifc.Instruction  = ifc.Address;
  assign ifc2.Instruction = ifc2.Address;

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
    .Clk(Clk), .Rst(Rst), .bus(ifc)
  );
  instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut_wrap (
    .Clk(Clk), .Rst(Rst), .bus(ifc2)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of {instr, pc+4} plus the PC and halted flag.
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] mpc = 32'h0;
  bit          mhalted = 1'b0;

  always @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      mq.delete();
      mpc     = 32'h0;
      mhalted = 1'b0;
    end else begin
      bit m_pop, m_push;
      m_pop  = (mq.size() > 0) && ifc.InstrReady && !ifc.Redirect;
      m_push = !mhalted && !ifc.Redirect && ((mq.size() < DEPTH) || m_pop);
      if (ifc.Redirect) begin
        mq.delete();
        mpc = {ifc.RedirectTarget[31:2], 2'b00};
      end else begin
        if (m_pop) void'(mq.pop_front());
        if (m_push) begin
          mq.push_back('{mpc, mpc + 32'd4});
          mpc = mpc + 32'd4;
        end
      end
      mhalted = ifc.Halt;
    end
  end

  always @(negedge Clk) begin
    chk("valid", {31'd0, ifc.InstrValid}, {31'd0, mq.size() > 0});
    chk("addr", ifc.Address, mpc);
    if (mq.size() > 0) begin
      chk("instr", ifc.InstrOut, mq[0].instr);
      chk("pc4", ifc.PCPlus4Out, mq[0].pc4);
    end
  end

  initial begin
    ifc.InstrReady      = 1'b1;
    ifc.Redirect        = 1'b0;
    ifc.RedirectTarget  = 32'h0;
    ifc.Halt            = 1'b0;
    ifc2.InstrReady     = 1'b1;
    ifc2.Redirect       = 1'b0;
    ifc2.RedirectTarget = 32'h0;
    ifc2.Halt           = 1'b0;

    // Reset state
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_valid", {31'd0, ifc.InstrValid}, 32'd0);
    chk("rst_instr", ifc.InstrOut, 32'h0);
    chk("rst_pc4", ifc.PCPlus4Out, 32'h0);
    chk("rst_addr", ifc.Address, 32'h0);
    chk("rst_addr_wrap", ifc2.Address, 32'hFFFF_FFF8);
    @(posedge Clk); #2 Rst = 1'b1;

    // Streaming with ready held high; wrap instance crosses 0
    @(posedge Clk); #1;
    chk("s0_instr", ifc.InstrOut, 32'h0);
    chk("s0_pc4", ifc.PCPlus4Out, 32'h4);
    chk("w0_instr", ifc2.InstrOut, 32'hFFFF_FFF8);
    @(posedge Clk); #1;
    chk("s1_instr", ifc.InstrOut, 32'h4);
    chk("w1_instr", ifc2.InstrOut, 32'hFFFF_FFFC);
    chk("w1_pc4", ifc2.PCPlus4Out, 32'h0);
    @(posedge Clk); #1;
    chk("s2_instr", ifc.InstrOut, 32'h8);
    chk("w2_instr", ifc2.InstrOut, 32'h0);
    repeat (3) @(posedge Clk);

    // Short reset pulse mid-stream, then back-pressure
    @(posedge Clk); #2;
    Rst = 1'b0;
    ifc.InstrReady = 1'b0;
    #1;
    chk("pulse_valid", {31'd0, ifc.InstrValid}, 32'd0);
    chk("pulse_addr", ifc.Address, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("pulse_fetch_cnt", ifc.FetchCount, 32'h0);
    chk("pulse_stall_cnt", ifc.StallCount, 32'h0);
    chk("pulse_flush_cnt", ifc.FlushCount, 32'h0);
`endif
    #4 Rst = 1'b1;
    repeat (5) @(posedge Clk);
    #1;
    chk("bp_addr", ifc.Address, 32'h8);
    chk("bp_instr", ifc.InstrOut, 32'h0);
    chk("bp_valid", {31'd0, ifc.InstrValid}, 32'd1);
    #1 ifc.InstrReady = 1'b1;
    @(posedge Clk); #1;
    chk("bp_next1", ifc.InstrOut, 32'h4);
    @(posedge Clk); #1;
    chk("bp_next2", ifc.InstrOut, 32'h8);
    chk("bp_next2_pc4", ifc.PCPlus4Out, 32'hC);

    // Redirect to unaligned 0x43 with the FIFO full; ready ignored that cycle
    #1 ifc.InstrReady = 1'b0;
    repeat (2) @(posedge Clk);
    #2;
    ifc.Redirect       = 1'b1;
    ifc.RedirectTarget = 32'h43;
    ifc.InstrReady     = 1'b1;
    @(posedge Clk); #1;
    chk("rd_valid", {31'd0, ifc.InstrValid}, 32'd0);
    chk("rd_addr", ifc.Address, 32'h40);
    #1;
    ifc.Redirect   = 1'b0;
    ifc.InstrReady = 1'b0;
    @(posedge Clk); #1;
    chk("rd_head_valid", {31'd0, ifc.InstrValid}, 32'd1);
    chk("rd_head_instr", ifc.InstrOut, 32'h40);
    chk("rd_head_pc4", ifc.PCPlus4Out, 32'h44);

    // Halt with two entries buffered: drain, PC held, then resume
    @(posedge Clk); #2 ifc.Halt = 1'b1;
    @(posedge Clk); #2 ifc.InstrReady = 1'b1;
    @(posedge Clk);
    @(posedge Clk); #1;
    chk("halt_valid", {31'd0, ifc.InstrValid}, 32'd0);
    chk("halt_addr", ifc.Address, 32'h48);
    repeat (2) @(posedge Clk);
    #1;
    chk("halt_valid2", {31'd0, ifc.InstrValid}, 32'd0);
    chk("halt_addr2", ifc.Address, 32'h48);
    #1 ifc.Halt = 1'b0;
    @(posedge Clk);
    @(posedge Clk); #1;
    chk("resume_instr", ifc.InstrOut, 32'h48);
    chk("resume_valid", {31'd0, ifc.InstrValid}, 32'd1);

    // Mixed directed pattern; i==200 combines Halt with a redirect near the top of memory
    for (int i = 0; i < 240; i++) begin
      @(posedge Clk); #2;
      ifc.InstrReady     = (i % 3) != 2;
      ifc.Halt           = ((i % 37) >= 30) || (i == 200);
      ifc.Redirect       = ((i % 19) == 7) || (i == 200);
      ifc.RedirectTarget = (i == 200) ? 32'hFFFF_FFFE : (i * 32'h0000_0104 + 32'd1);
    end
    @(posedge Clk); #2;
    ifc.InstrReady = 1'b1;
    ifc.Halt       = 1'b0;
    ifc.Redirect   = 1'b0;
    repeat (6) @(posedge Clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
